// File: rtl/wb_stage_ld_if.sv
// MEM -> WB handshake bus.
//   master : MEM side, drives the instruction fields and ms_to_ws_valid
//   slave  : WB side, drives ws_allowin
interface wb_stage_ld_if #(
  parameter int REG_AW = 5
);
  logic              ms_to_ws_valid;
  logic              ws_allowin;
  logic [31:0]       ms_pc;
  logic              ms_gr_we;
  logic [REG_AW-1:0] ms_dest;
  logic [31:0]       ms_result;
  logic              ms_ex;
  logic              ms_res_from_mem;
  logic [2:0]        ms_mem_op;
  logic [1:0]        ms_byte_off;
  logic [31:0]       ms_rt_value;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_ex,
           ms_res_from_mem, ms_mem_op, ms_byte_off, ms_rt_value,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_ex,
           ms_res_from_mem, ms_mem_op, ms_byte_off, ms_rt_value,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage_ld.sv
// Write-back stage with load-data formatting, load-data wait, forwarding
// and a retired-instruction counter.
//   clk, reset            clock, synchronous active-high reset
//   ms                    MEM->WB handshake bus (slave side)
//   data_ok_i/rdata_i     DCache read return
//   rf_*_o                register-file write port
//   ws_fwd_*_o            forwarding to ID, with load-pending stall flag
//   retire_cnt_o          retired non-excepting instruction count
//   debug_wb_*_o          trace port
//
// Load wait FSM:
//   state | meaning
//   IDLE  | no load data held; data comes straight from data_rdata_i
//   HAVE  | load data already captured in data_buf_q, waiting to retire
module wb_stage_ld #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32,
  parameter int WEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  wb_stage_ld_if.slave      ms,
  input  logic              data_ok_i,
  input  logic [31:0]       data_rdata_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [31:0]       rf_wdata_o,
  output logic              ws_fwd_valid_o,
  output logic [REG_AW-1:0] ws_fwd_dest_o,
  output logic [31:0]       ws_fwd_data_o,
  output logic              ws_fwd_blocked_o,
  output logic [CNT_W-1:0]  retire_cnt_o,
  output logic [31:0]       debug_wb_pc_o,
  output logic [WEN_W-1:0]  debug_wb_rf_wen_o,
  output logic [REG_AW-1:0] debug_wb_rf_wnum_o,
  output logic [31:0]       debug_wb_rf_wdata_o
);

  typedef enum logic {IDLE, HAVE} state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic              gr_we;
    logic [REG_AW-1:0] dest;
    logic [31:0]       result;
    logic              ex;
    logic              res_from_mem;
    logic [2:0]        mem_op;
    logic [1:0]        byte_off;
    logic [31:0]       rt_value;
  } fields_t;

  state_e           state_q;
  logic [31:0]      data_buf_q;
  logic             ws_valid_q, ws_valid_d;
  fields_t          f_q, f_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic        got_data, need_data, ready_go, allowin, retire;
  logic [31:0] ld_word, ld_fmt, final_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign got_data  = (state_q == HAVE);
  assign need_data = ws_valid_q & f_q.res_from_mem & ~f_q.ex;
  assign ready_go  = ~need_data | got_data | data_ok_i;
  assign allowin   = ~ws_valid_q | ready_go;
  assign retire    = ws_valid_q & ready_go;
  assign ms.ws_allowin = allowin;

  always_comb begin
    ws_valid_d   = allowin ? ms.ms_to_ws_valid : ws_valid_q;
    f_d          = f_q;
    if (ms.ms_to_ws_valid && allowin) begin
      f_d.pc           = ms.ms_pc;
      f_d.gr_we        = ms.ms_gr_we;
      f_d.dest         = ms.ms_dest;
      f_d.result       = ms.ms_result;
      f_d.ex           = ms.ms_ex;
      f_d.res_from_mem = ms.ms_res_from_mem;
      f_d.mem_op       = ms.ms_mem_op;
      f_d.byte_off     = ms.ms_byte_off;
      f_d.rt_value     = ms.ms_rt_value;
    end
    retire_cnt_d = (retire && !f_q.ex) ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q   <= 1'b0;
      f_q          <= '0;
      retire_cnt_q <= '0;
    end else begin
      ws_valid_q   <= ws_valid_d;
      f_q          <= f_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Retire has priority so a load that takes its data and retires in the
  // same cycle does not leave HAVE set for the next instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      data_buf_q <= '0;
    end else begin
      if (data_ok_i && need_data && !got_data) data_buf_q <= data_rdata_i;
      case (state_q)
        IDLE: if (!retire && data_ok_i && need_data) state_q <= HAVE;
        HAVE: if (retire) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ld_word = got_data ? data_buf_q : data_rdata_i;
    case (f_q.byte_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = f_q.byte_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (f_q.mem_op)
      3'd1: ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd2: ld_fmt = {24'd0, ld_byte};
      3'd3: ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'd4: ld_fmt = {16'd0, ld_half};
      3'd5: begin
        case (f_q.byte_off)
          2'd0:    ld_fmt = {ld_word[7:0],  f_q.rt_value[23:0]};
          2'd1:    ld_fmt = {ld_word[15:0], f_q.rt_value[15:0]};
          2'd2:    ld_fmt = {ld_word[23:0], f_q.rt_value[7:0]};
          default: ld_fmt = ld_word;
        endcase
      end
      3'd6: begin
        case (f_q.byte_off)
          2'd0:    ld_fmt = ld_word;
          2'd1:    ld_fmt = {f_q.rt_value[31:24], ld_word[31:8]};
          2'd2:    ld_fmt = {f_q.rt_value[31:16], ld_word[31:16]};
          default: ld_fmt = {f_q.rt_value[31:8],  ld_word[31:24]};
        endcase
      end
      default: ld_fmt = ld_word;
    endcase
    final_data = f_q.res_from_mem ? ld_fmt : f_q.result;
  end

  assign rf_we_o             = retire & f_q.gr_we & ~f_q.ex;
  assign rf_waddr_o          = f_q.dest;
  assign rf_wdata_o          = final_data;
  assign ws_fwd_valid_o      = ws_valid_q & f_q.gr_we & ~f_q.ex & (f_q.dest != '0);
  assign ws_fwd_dest_o       = f_q.dest;
  assign ws_fwd_data_o       = final_data;
  assign ws_fwd_blocked_o    = ws_fwd_valid_o & need_data & ~got_data & ~data_ok_i;
  assign retire_cnt_o        = retire_cnt_q;
  assign debug_wb_pc_o       = f_q.pc;
  assign debug_wb_rf_wen_o   = {WEN_W{rf_we_o}};
  assign debug_wb_rf_wnum_o  = f_q.dest;
  assign debug_wb_rf_wdata_o = final_data;

endmodule

// File: tb/tb_wb_stage_ld.sv
module tb_wb_stage_ld;
  logic        clk = 1'b0;
  logic        reset;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        rf_we, fwd_valid, fwd_blocked;
  logic [4:0]  rf_waddr, fwd_dest, wnum;
  logic [31:0] rf_wdata, fwd_data, dbg_pc, dbg_wdata;
  logic [3:0]  retire_cnt, dbg_wen;
  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  wb_stage_ld_if #(.REG_AW(5)) ms_if ();

  wb_stage_ld #(.REG_AW(5), .CNT_W(4), .WEN_W(4)) dut (
    .clk(clk), .reset(reset), .ms(ms_if.slave),
    .data_ok_i(data_ok), .data_rdata_i(data_rdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .ws_fwd_valid_o(fwd_valid), .ws_fwd_dest_o(fwd_dest), .ws_fwd_data_o(fwd_data),
    .ws_fwd_blocked_o(fwd_blocked), .retire_cnt_o(retire_cnt),
    .debug_wb_pc_o(dbg_pc), .debug_wb_rf_wen_o(dbg_wen),
    .debug_wb_rf_wnum_o(wnum), .debug_wb_rf_wdata_o(dbg_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                       input logic [31:0] result, input logic ex, input logic rfm,
                       input logic [2:0] op, input logic [1:0] off, input logic [31:0] rt);
    ms_if.ms_to_ws_valid  = 1'b1;
    ms_if.ms_pc           = pc;
    ms_if.ms_gr_we        = gr_we;
    ms_if.ms_dest         = dest;
    ms_if.ms_result       = result;
    ms_if.ms_ex           = ex;
    ms_if.ms_res_from_mem = rfm;
    ms_if.ms_mem_op       = op;
    ms_if.ms_byte_off     = off;
    ms_if.ms_rt_value     = rt;
  endtask

  initial begin
    reset = 1'b1;
    data_ok = 1'b0;
    data_rdata = '0;
    drive(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
    ms_if.ms_to_ws_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_blocked", fwd_blocked, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_wen", dbg_wen, 0);
    chk("rst_allowin", ms_if.ws_allowin, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU op
    drive(32'hBFC00010, 1'b1, 5'd3, 32'h1234, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("alu_we", rf_we, 1);
    chk("alu_waddr", rf_waddr, 3);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_pc", dbg_pc, 32'hBFC00010);
    chk("alu_wen", dbg_wen, 4'hF);
    chk("alu_fwd", {fwd_valid, 3'b0, fwd_dest}, 9'h103);
    tick();
    exp_cnt++;
    @(negedge clk);
    chk("alu_cnt", retire_cnt, exp_cnt % 16);
    chk("alu_idle_we", rf_we, 0);

    // LB, byte_off=2, data arrives 3 cycles after entry
    drive(32'hBFC00014, 1'b1, 5'd5, 32'hDEAD, 1'b0, 1'b1, 3'd1, 2'd2, 32'h0);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lb_wait_allowin", ms_if.ws_allowin, 0);
      chk("lb_wait_blocked", fwd_blocked, 1);
      chk("lb_wait_we", rf_we, 0);
      tick();
    end
    data_ok = 1'b1;
    data_rdata = 32'h00800000;
    @(negedge clk);
    chk("lb_we", rf_we, 1);
    chk("lb_wdata", rf_wdata, 32'hFFFFFF80);
    chk("lb_allowin", ms_if.ws_allowin, 1);
    chk("lb_blocked", fwd_blocked, 0);
    tick();
    data_ok = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk("lb_single_write", rf_we, 0);
    chk("lb_cnt", retire_cnt, exp_cnt % 16);

    // LWR / LWL / LHU back to back, data_ok in each entry cycle
    drive(32'hBFC00018, 1'b1, 5'd6, 32'h0, 1'b0, 1'b1, 3'd6, 2'd1, 32'hAABBCCDD);
    tick();
    drive(32'hBFC0001C, 1'b1, 5'd7, 32'h0, 1'b0, 1'b1, 3'd5, 2'd0, 32'hAABBCCDD);
    data_ok = 1'b1;
    data_rdata = 32'h11223344;
    @(negedge clk);
    chk("lwr_we", rf_we, 1);
    chk("lwr_wdata", rf_wdata, 32'hAA112233);
    chk("lwr_allowin", ms_if.ws_allowin, 1);
    tick();
    drive(32'hBFC00020, 1'b1, 5'd8, 32'h0, 1'b0, 1'b1, 3'd4, 2'd2, 32'h0);
    @(negedge clk);
    chk("lwl_wdata", rf_wdata, 32'h44BBCCDD);
    chk("lwl_we", rf_we, 1);
    data_rdata = 32'h8001FFFF;
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("lhu_wdata", rf_wdata, 32'h00008001);
    chk("lhu_waddr", rf_waddr, 8);
    tick();
    data_ok = 1'b0;
    exp_cnt += 3;
    @(negedge clk);
    chk("ld3_cnt", retire_cnt, exp_cnt % 16);

    // Excepting instruction (a load with no data: must not stall)
    drive(32'hBFC00024, 1'b1, 5'd9, 32'h5555, 1'b1, 1'b1, 3'd0, 2'd0, 32'h0);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("ex_we", rf_we, 0);
    chk("ex_fwd", fwd_valid, 0);
    chk("ex_allowin", ms_if.ws_allowin, 1);
    tick();
    @(negedge clk);
    chk("ex_cnt", retire_cnt, exp_cnt % 16);

    // Reset in the middle of a load wait, then a late data_ok
    drive(32'hBFC00028, 1'b1, 5'd4, 32'h0, 1'b0, 1'b1, 3'd0, 2'd0, 32'h0);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("rl_wait_allowin", ms_if.ws_allowin, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_ok = 1'b1;
    data_rdata = 32'hCAFEF00D;
    exp_cnt = 0;
    @(negedge clk);
    chk("rl_we", rf_we, 0);
    chk("rl_fwd", fwd_valid, 0);
    chk("rl_allowin", ms_if.ws_allowin, 1);
    chk("rl_cnt", retire_cnt, 0);
    tick();
    data_ok = 1'b0;

    // 17 back-to-back ALU ops, 4-bit counter wraps to 1
    drive(32'h1000, 1'b1, 5'd1, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i < 16)
        drive(32'h1000 + 4 * (i + 1), 1'b1, 5'(i % 31 + 2), 32'(i + 1), 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
      else
        ms_if.ms_to_ws_valid = 1'b0;
      @(negedge clk);
      chk("b2b_we", rf_we, 1);
      chk("b2b_wdata", rf_wdata, 32'(i));
    end
    tick();
    exp_cnt += 17;
    @(negedge clk);
    chk("wrap_cnt", retire_cnt, 1);

    // dest=0: writes RF but never forwards
    drive(32'h2000, 1'b1, 5'd0, 32'h77, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("d0_fwd", fwd_valid, 0);
    chk("d0_we", rf_we, 1);
    tick();
    exp_cnt++;
    @(negedge clk);
    chk("d0_cnt", retire_cnt, exp_cnt % 16);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
